cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
- Synthesizable simulation and bring-up harness that sits between the board or bench reset and the pipeline CPU.
- Generates a parametrised CPU reset window and bounds the run to a fixed number of cycles.
- Watches the CPU's LED and 7-segment outputs and logs every change, with a cycle timestamp, into a FIFO drained through a valid/ready port.
- Replaces hand-timed reset/finish delays with a self-timed, self-checking run controller, usable both in benches and on hardware.

Parameters:
- RESET_CYCLES, 10, cycles cpu_reset stays high after reset deasserts (≥1)
- MAX_CYCLES, 30000, RUN-state cycles before DONE (≥1)
- LED_W, 8, width of LED input
- DIG_W, 12, width of 7-segment/BCD input
- CYC_W, 32, width of cycle counter and timestamps
- DEPTH, 16, event FIFO depth (power of 2, ≥2)
- WDOG_CYCLES, 4096, no-change limit for watchdog (used only with the optional feature)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- led  in  LED_W  CPU LED output
- digital  in  DIG_W  CPU 7-segment output
- cpu_reset  out  1  reset to CPU, active-high
- run_cycles  out  CYC_W  RUN cycles elapsed
- evt_valid  out  1  event FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_cycle  out  CYC_W  timestamp of head event
- evt_led  out  LED_W  LED value of head event
- evt_digital  out  DIG_W  digital value of head event
- overflow  out  1  sticky: an event was dropped
- done  out  1  run finished normally
- timeout  out  1  watchdog fired

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high. All state is sampled on the rising edge of `clk`.
- Reset values: state=HOLD, cpu_reset=1, run_cycles=0, hold counter=0, FIFO empty, evt_valid=0, evt_* =0, overflow=0, done=0, timeout=0, prev_led=0, prev_digital=0.
- FSM states: HOLD, RUN, DONE, TIMEOUT.
- HOLD:
  - cpu_reset=1; hold counter increments each cycle.
  - prev_led/prev_digital load led/digital every cycle.
  - When the counter reaches RESET_CYCLES-1, go to RUN.
  - Result: cpu_reset is high for exactly RESET_CYCLES cycles after reset deasserts.
- RUN:
  - cpu_reset=0; run_cycles increments each cycle, holding value k during the (k+1)-th RUN cycle.
  - Change detect: if {led,digital} != {prev_led,prev_digital}, push {run_cycles, led, digital} and update prev.
  - When run_cycles == MAX_CYCLES-1, go to DONE next cycle; the final cycle can still push.
- DONE:
  - done=1 and cpu_reset=1, both held until reset.
  - run_cycles frozen; no pushes; the FIFO keeps draining.
- TIMEOUT: same as DONE, but timeout=1 and done=0.
- FIFO timing:
  - Registered, first-word-fall-through: a push is visible on evt_valid/evt_* the next cycle.
  - Pop occurs when evt_valid && evt_ready.
  - evt_* hold their value while evt_valid && !evt_ready.
- Full FIFO:
  - A push without a simultaneous pop is dropped and overflow set (sticky).
  - A push and pop in the same cycle on a full FIFO both succeed, with no overflow.
- Empty FIFO: evt_ready is ignored; evt_* hold their last values.
- Pointers: log2(DEPTH)+1 bits, wrapping naturally.
- run_cycles: saturates at all-ones; no wrap.
- Reset mid-run: returns to HOLD, the FIFO is flushed, and all sticky flags are cleared in the same cycle.

Optional Feature:
- Macro: CPU_RUN_MONITOR_WDOG_EN.
- Defined:
  - An idle counter counts consecutive RUN cycles with no change and clears on any change.
  - When the idle counter reaches WDOG_CYCLES-1 with no change, go to TIMEOUT next cycle.
  - If MAX_CYCLES-1 is reached in the same cycle, DONE takes priority.
- Undefined: no idle counter; timeout is tied to 0; the TIMEOUT state is unreachable.

Decomposition:
- Package cpu_run_monitor_pkg holds:
  - state enum (HOLD/RUN/DONE/TIMEOUT)
  - event struct {cycle, led, digital}, parametrised via the package's default widths
- Sub-module run_event_fifo: generic sync FIFO (DEPTH, WIDTH, push/full/pop/empty, overflow flag), reusable elsewhere.

Test Plan:
- Reset sequence: reset high 5 cycles then low, RESET_CYCLES=10 → cpu_reset low on exactly the 11th cycle after deassert; run_cycles=0 in the first RUN cycle.
- Change logging: led 0→0x01 at run_cycles=3, digital 0→0x123 at 7, both change at 9 → 3 events (3,0x01,0x000), (7,0x01,0x123), (9,new,new) read in order with evt_ready=1.
- Termination: MAX_CYCLES=50 → done=1 after run_cycles=49; cpu_reset=1; run_cycles stays 49; later input changes produce no events.
- Backpressure and overflow: DEPTH=4, evt_ready=0, 6 changes → 4 events held and overflow=1. Then with full FIFO, a simultaneous push and pop → count stays 4, overflow unchanged.
- Watchdog (macro defined): WDOG_CYCLES=20, constant inputs → timeout=1, done=0, cpu_reset=1 after 20 idle cycles. The same stimulus with the macro undefined → timeout stays 0 and the run ends in DONE.
- Reset mid-run: reset asserted at run_cycles=25 with 3 queued events → next cycle evt_valid=0, overflow=0, state HOLD, cpu_reset=1.

Source files
------------

// File: rtl/cpu_run_monitor_pkg.sv
// Shared types for the CPU run monitor: run-controller states and the logged event record.
package cpu_run_monitor_pkg;

    localparam int DEF_LED_W = 8;
    localparam int DEF_DIG_W = 12;
    localparam int DEF_CYC_W = 32;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_t;

    typedef struct packed {
        logic [DEF_CYC_W-1:0] cycle;
        logic [DEF_LED_W-1:0] led;
        logic [DEF_DIG_W-1:0] digital;
    } run_event_t;

endpackage

// File: rtl/run_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head word and a sticky drop flag.
module run_event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      wr_ptr_next, rd_ptr_next;
    logic [AW:0]      count;
    logic [WIDTH-1:0] head_reg;
    logic             overflow_reg;
    logic             push_ok, pop_ok;

    assign count       = wr_ptr_reg - rd_ptr_reg;
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (count == (AW+1)'(DEPTH));
    assign pop_ok      = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign push_ok     = push && (!full || pop_ok);
    assign wr_ptr_next = wr_ptr_reg + (AW+1)'(push_ok);
    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop_ok);
    assign pop_data    = head_reg;
    assign overflow    = overflow_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            // Head only moves while something is queued; an empty FIFO keeps showing its last word.
            if (wr_ptr_next != rd_ptr_next) begin
                if (push_ok && (rd_ptr_next == wr_ptr_reg)) begin
                    head_reg <= push_data;
                end else begin
                    head_reg <= mem[rd_ptr_next[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Self-timed CPU reset/run controller that timestamps every LED/7-segment change into an event FIFO.
// Optional no-change watchdog enabled by defining CPU_RUN_MONITOR_WDOG_EN.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int RESET_CYCLES = 10,
    parameter int MAX_CYCLES   = 30000,
    parameter int LED_W        = DEF_LED_W,
    parameter int DIG_W        = DEF_DIG_W,
    parameter int CYC_W        = DEF_CYC_W,
    parameter int DEPTH        = 16,
    parameter int WDOG_CYCLES  = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] led,
    input  logic [DIG_W-1:0] digital,
    output logic             cpu_reset,
    output logic [CYC_W-1:0] run_cycles,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CYC_W-1:0] evt_cycle,
    output logic [LED_W-1:0] evt_led,
    output logic [DIG_W-1:0] evt_digital,
    output logic             overflow,
    output logic             done,
    output logic             timeout
);
    localparam int EVT_W  = CYC_W + LED_W + DIG_W;
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    run_state_t       state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [CYC_W-1:0] run_cycles_reg;
    logic [LED_W-1:0] prev_led_reg;
    logic [DIG_W-1:0] prev_digital_reg;
    logic             cpu_reset_reg, done_reg, timeout_reg;

    logic             change, push, at_max, wdog_fire;
    logic             fifo_full, fifo_empty;
    logic [EVT_W-1:0] push_word, head_word;

    assign change    = {led, digital} != {prev_led_reg, prev_digital_reg};
    assign push      = (state_reg == ST_RUN) && change;
    assign at_max    = (run_cycles_reg == CYC_W'(MAX_CYCLES - 1));
    assign push_word = {run_cycles_reg, led, digital};

`ifdef CPU_RUN_MONITOR_WDOG_EN
    localparam int IDLE_W = $clog2(WDOG_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt_reg;

    assign wdog_fire = !change && (idle_cnt_reg == IDLE_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (state_reg != ST_RUN) || change) begin
            idle_cnt_reg <= '0;
        end else if (!wdog_fire) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    // Watchdog compiled out: the expression is constant false.
    assign wdog_fire = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_HOLD;
            hold_cnt_reg     <= '0;
            run_cycles_reg   <= '0;
            prev_led_reg     <= '0;
            prev_digital_reg <= '0;
            cpu_reset_reg    <= 1'b1;
            done_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    prev_led_reg     <= led;
                    prev_digital_reg <= digital;
                    hold_cnt_reg     <= hold_cnt_reg + 1'b1;
                    if (hold_cnt_reg == HOLD_W'(RESET_CYCLES - 1)) begin
                        state_reg     <= ST_RUN;
                        cpu_reset_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (change) begin
                        prev_led_reg     <= led;
                        prev_digital_reg <= digital;
                    end
                    // The last RUN cycle's count is the frozen final value.
                    if (!at_max && !wdog_fire && (run_cycles_reg != '1)) begin
                        run_cycles_reg <= run_cycles_reg + 1'b1;
                    end
                    if (at_max) begin
                        state_reg     <= ST_DONE;
                        done_reg      <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                    end else if (wdog_fire) begin
                        state_reg     <= ST_TIMEOUT;
                        timeout_reg   <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    run_event_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EVT_W)
    ) u_fifo (
        .clk      (clk),
        .srst     (reset),
        .push     (push),
        .push_data(push_word),
        .full     (fifo_full),
        .pop      (evt_ready),
        .pop_data (head_word),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign {evt_cycle, evt_led, evt_digital} = head_word;
    assign evt_valid  = !fifo_empty;
    assign cpu_reset  = cpu_reset_reg;
    assign run_cycles = run_cycles_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor against a cycle-indexed behavioural model of the run and event log.
module tb_cpu_run_monitor;
    import cpu_run_monitor_pkg::*;

    localparam int R     = 10;
    localparam int MAXC  = 50;
    localparam int DEPTH = 4;
    localparam int WDOG  = 20;
    localparam int LED_W = DEF_LED_W;
    localparam int DIG_W = DEF_DIG_W;
    localparam int CYC_W = DEF_CYC_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [LED_W-1:0] led = '0;
    logic [DIG_W-1:0] digital = '0;
    logic             evt_ready = 1'b0;
    logic             cpu_reset, evt_valid, overflow, done, timeout;
    logic [CYC_W-1:0] run_cycles, evt_cycle;
    logic [LED_W-1:0] evt_led;
    logic [DIG_W-1:0] evt_digital;

    cpu_run_monitor #(
        .RESET_CYCLES(R), .MAX_CYCLES(MAXC), .LED_W(LED_W), .DIG_W(DIG_W),
        .CYC_W(CYC_W), .DEPTH(DEPTH), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .led(led), .digital(digital),
        .cpu_reset(cpu_reset), .run_cycles(run_cycles),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_cycle(evt_cycle),
        .evt_led(evt_led), .evt_digital(evt_digital),
        .overflow(overflow), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: t = cycles since reset deassert; RUN spans t >= R until the run ends.
    int               m_t = 0;
    bit               m_ended = 1'b0;
    bit               m_to = 1'b0;
    int               m_end_k = 0;
    int               m_idle = 0;
    bit               m_ovf = 1'b0;
    logic [LED_W-1:0] m_pled = '0;
    logic [DIG_W-1:0] m_pdig = '0;
    run_event_t       m_q[$];
    run_event_t       m_head = '0;

    task automatic model_edge(input bit rst, input logic [LED_W-1:0] l,
                              input logic [DIG_W-1:0] d, input bit rdy);
        bit         pop_now, ev, chg;
        int         k;
        run_event_t e;
        if (rst) begin
            m_t = 0; m_ended = 0; m_to = 0; m_end_k = 0; m_idle = 0; m_ovf = 0;
            m_q.delete(); m_head = '0;
            return;
        end
        pop_now = rdy && (m_q.size() > 0);
        ev = 1'b0;
        e  = '0;
        if (m_t >= R && !m_ended) begin
            k   = m_t - R;
            chg = ({l, d} != {m_pled, m_pdig});
            if (chg) begin
                ev = 1'b1;
                e.cycle = CYC_W'(k); e.led = l; e.digital = d;
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (k == MAXC - 1) begin
                m_ended = 1'b1; m_end_k = k;
            end
`ifdef CPU_RUN_MONITOR_WDOG_EN
            else if (!chg && m_idle == WDOG) begin
                m_ended = 1'b1; m_to = 1'b1; m_end_k = k;
            end
`endif
        end
        m_pled = l;
        m_pdig = d;
        m_t++;
        if (pop_now) begin
            $display("evt  cycle=%0d led=%02h digital=%03h", m_q[0].cycle, m_q[0].led, m_q[0].digital);
            void'(m_q.pop_front());
        end
        if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1'b1;
        end
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic check_all();
        int exp_run;
        exp_run = m_ended ? m_end_k : ((m_t >= R) ? (m_t - R) : 0);
        check("cpu_reset",   64'(cpu_reset),  64'(m_ended || (m_t < R)));
        check("run_cycles",  64'(run_cycles), 64'(exp_run));
        check("done",        64'(done),       64'(m_ended && !m_to));
        check("timeout",     64'(timeout),    64'(m_to));
        check("overflow",    64'(overflow),   64'(m_ovf));
        check("evt_valid",   64'(evt_valid),  64'(m_q.size() > 0));
        check("evt_cycle",   64'(evt_cycle),  64'(m_head.cycle));
        check("evt_led",     64'(evt_led),    64'(m_head.led));
        check("evt_digital", 64'(evt_digital),64'(m_head.digital));
    endtask

    task automatic cycle(input bit rst, input bit rdy);
        reset     = rst;
        evt_ready = rdy;
        model_edge(rst, led, digital, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One run: reset, then ncyc cycles changing inputs with p_chg% and ready with p_rdy%.
    task automatic run_test(input int nreset, input int ncyc, input int p_chg,
                            input int p_rdy, input int rst_at);
        int sel;
        repeat (nreset) cycle(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(1, 100) <= p_chg) begin
                sel = $urandom_range(0, 2);
                if (sel != 1) led = LED_W'($urandom);
                if (sel != 0) digital = DIG_W'($urandom);
            end
            cycle(i == rst_at, $urandom_range(1, 100) <= p_rdy);
        end
    endtask

    initial begin
        led = 8'h00; digital = 12'h000;
        // Constant inputs: ends in DONE, or TIMEOUT when the watchdog is built in.
        run_test(5, R + MAXC + 15, 0, 50, -1);
        // Sparse changes, mostly-ready consumer.
        run_test(2, R + MAXC + 15, 20, 80, -1);
        // Stalled consumer with dense changes fills the FIFO and drops events.
        run_test(1, R + 30, 70, 0, -1);
        // Full FIFO with intermittent pops exercises push+pop while full.
        run_test(1, R + MAXC + 10, 80, 50, -1);
        // Reset mid-run around run_cycles=25 with events queued.
        run_test(1, R + 40, 30, 0, R + 25);
        for (int r = 0; r < 20; r++) begin
            run_test($urandom_range(1, 4), $urandom_range(R + 5, R + MAXC + 20),
                     $urandom_range(0, 90), $urandom_range(0, 100),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, R + MAXC) : -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
